// File: rtl/systolic_sched_pkg.sv
// Shared types and helpers for the systolic job scheduler and its round-robin arbiter.
package systolic_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } sched_state_e;

  // Requester index width; never narrower than one bit.
  function automatic int unsigned req_idx_width(input int unsigned nreq);
    return (nreq <= 1) ? 1 : $clog2(nreq);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the requester after the last grant.
module rr_arbiter
  import systolic_sched_pkg::*;
#(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IDXW = req_idx_width(NREQ)
) (
  input  logic            clock,
  input  logic            nreset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant_c,
  output logic [IDXW-1:0] grant_idx_c,
  output logic            any_c
);

  logic [IDXW-1:0] ptr_q;
  logic [IDXW-1:0] cand;
  logic            found;

  assign any_c = |req;

  // Rotating priority search starting one past the last granted requester.
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    cand        = '0;
    found       = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IDXW'((32'(ptr_q) + i) % NREQ);
      if (!found && req[cand]) begin
        found         = 1'b1;
        grant_c[cand] = 1'b1;
        grant_idx_c   = cand;
      end
    end
  end

  // Pointer resets to the last requester so requester 0 wins first.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      ptr_q <= IDXW'(NREQ - 1);
    end else if (advance && any_c) begin
      ptr_q <= grant_idx_c;
    end
  end

endmodule

// File: rtl/systolic_job_scheduler.sv
// Serialises matrix-multiply jobs from several requesters onto one systolic array.
// Optional RUN watchdog enabled by defining SYSTOLIC_SCHED_TIMEOUT_EN.
module systolic_job_scheduler
  import systolic_sched_pkg::*;
#(
  parameter  int unsigned WIDTH       = 16,
  parameter  int unsigned WIDTHx      = 4,
  parameter  int unsigned SIZE        = 3,
  parameter  int unsigned NREQ        = 2,
  parameter  int unsigned TIMEOUT_CYC = 4 * SIZE + 4,
  localparam int unsigned IDXW        = req_idx_width(NREQ)
) (
  input  logic                                           clock,
  input  logic                                           nreset,
  input  logic [NREQ-1:0]                                req_valid,
  output logic [NREQ-1:0]                                req_ready,
  input  logic [NREQ-1:0][SIZE-1:0][SIZE-1:0][WIDTHx-1:0] req_a,
  input  logic [NREQ-1:0][SIZE-1:0][SIZE-1:0][WIDTHx-1:0] req_b,
  output logic                                           mm_nreset,
  output logic                                           mm_valid,
  output logic [SIZE-1:0][SIZE-1:0][WIDTHx-1:0]          mm_a,
  output logic [SIZE-1:0][SIZE-1:0][WIDTHx-1:0]          mm_b,
  input  logic                                           mm_ready,
  input  logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0]           mm_c,
  output logic                                           rsp_valid,
  input  logic                                           rsp_ready,
  output logic [IDXW-1:0]                                rsp_id,
  output logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0]           rsp_c,
  output logic                                           rsp_err
);

  if ((NREQ < 2) || (NREQ > 8)) begin : g_bad_nreq
    $error("systolic_job_scheduler: NREQ must be within 2..8");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("systolic_job_scheduler: TIMEOUT_CYC must be at least 1");
  end

  sched_state_e    state_q;
  sched_state_e    state_d;
  logic [NREQ-1:0] grant_c;
  logic [IDXW-1:0] grant_idx_c;
  logic            req_any_c;
  logic            accept_c;
  logic            capture_c;
  logic            mm_nreset_q;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clock       (clock),
    .nreset      (nreset),
    .req         (req_valid),
    .advance     (accept_c),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c),
    .any_c       (req_any_c)
  );

`ifdef SYSTOLIC_SCHED_TIMEOUT_EN
  localparam int unsigned CNTW = $clog2(TIMEOUT_CYC + 1);

  logic [CNTW-1:0] run_cnt_q;
  logic            timeout_c;
`endif

  // Next-state and per-cycle strobes.
  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    capture_c = 1'b0;
`ifdef SYSTOLIC_SCHED_TIMEOUT_EN
    timeout_c = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_any_c) begin
          accept_c = 1'b1;
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_START;
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (mm_ready) begin
          capture_c = 1'b1;
          state_d   = S_DONE;
        end
`ifdef SYSTOLIC_SCHED_TIMEOUT_EN
        else if (run_cnt_q == CNTW'(TIMEOUT_CYC - 1)) begin
          timeout_c = 1'b1;
          state_d   = S_DONE;
        end
`endif
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Accept pulse must coincide with the requester's valid, so it is decoded, not registered.
  assign req_ready = (accept_c && nreset) ? grant_c : '0;
  assign mm_nreset = nreset & mm_nreset_q;

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q     <= S_IDLE;
      mm_valid    <= 1'b0;
      mm_nreset_q <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_c       <= '0;
      mm_a        <= '0;
      mm_b        <= '0;
    end else begin
      state_q     <= state_d;
      mm_valid    <= (state_d == S_START);
      mm_nreset_q <= (state_d != S_CLEAR);
      rsp_valid   <= (state_d == S_DONE);
      if (accept_c) begin
        mm_a   <= req_a[grant_idx_c];
        mm_b   <= req_b[grant_idx_c];
        rsp_id <= grant_idx_c;
      end
      if (capture_c) begin
        rsp_c <= mm_c;
      end
`ifdef SYSTOLIC_SCHED_TIMEOUT_EN
      else if (timeout_c) begin
        rsp_c <= '0;
      end
`endif
    end
  end

`ifdef SYSTOLIC_SCHED_TIMEOUT_EN
  // Counts RUN cycles; restarts every time RUN is entered.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      run_cnt_q <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (state_q == S_RUN) run_cnt_q <= run_cnt_q + CNTW'(1);
      else                  run_cnt_q <= '0;
      if (capture_c)      rsp_err <= 1'b0;
      else if (timeout_c) rsp_err <= 1'b1;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_job_scheduler.sv
// Self-checking bench for systolic_job_scheduler with a behavioural array model and RR reference.
module tb_systolic_job_scheduler;

  localparam int unsigned WIDTH       = 16;
  localparam int unsigned WIDTHX      = 4;
  localparam int unsigned SIZE        = 3;
  localparam int unsigned NREQ        = 2;
  localparam int unsigned TIMEOUT_CYC = 4 * SIZE + 4;

  typedef logic [SIZE-1:0][SIZE-1:0][WIDTHX-1:0] mat_t;
  typedef logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0]  res_t;

  typedef struct {
    logic [NREQ-1:0] mask;
    int              lat;
    int              hold;
    int              kind;
    int              exp_id;
  } vec_t;

  logic                                           clock = 1'b0;
  logic                                           nreset;
  logic [NREQ-1:0]                                req_valid;
  logic [NREQ-1:0]                                req_ready;
  logic [NREQ-1:0][SIZE-1:0][SIZE-1:0][WIDTHX-1:0] req_a;
  logic [NREQ-1:0][SIZE-1:0][SIZE-1:0][WIDTHX-1:0] req_b;
  logic                                           mm_nreset;
  logic                                           mm_valid;
  mat_t                                           mm_a;
  mat_t                                           mm_b;
  logic                                           mm_ready;
  res_t                                           mm_c;
  logic                                           rsp_valid;
  logic                                           rsp_ready;
  logic [0:0]                                     rsp_id;
  res_t                                           rsp_c;
  logic                                           rsp_err;

  int   total = 0;
  int   bad   = 0;
  int   arr_lat = 1;
  int   arr_cnt;
  logic stray_en = 1'b0;
  int   model_last = NREQ - 1;

  always #5 clock = ~clock;

  systolic_job_scheduler #(
    .WIDTH (WIDTH), .WIDTHx (WIDTHX), .SIZE (SIZE), .NREQ (NREQ), .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clock     (clock),
    .nreset    (nreset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mm_nreset (mm_nreset),
    .mm_valid  (mm_valid),
    .mm_a      (mm_a),
    .mm_b      (mm_b),
    .mm_ready  (mm_ready),
    .mm_c      (mm_c),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_c     (rsp_c),
    .rsp_err   (rsp_err)
  );

  function automatic res_t mat_mul(input mat_t a, input mat_t b);
    res_t c;
    int   acc;
    for (int r = 0; r < SIZE; r++)
      for (int col = 0; col < SIZE; col++) begin
        acc = 0;
        for (int k = 0; k < SIZE; k++) acc += int'(a[r][k]) * int'(b[k][col]);
        c[r][col] = WIDTH'(acc);
      end
    return c;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int r = 0; r < SIZE; r++)
      for (int col = 0; col < SIZE; col++) m[r][col] = WIDTHX'($urandom);
    return m;
  endfunction

  // Reference round-robin: first requesting index after the previous winner.
  function automatic int rr_pick(input logic [NREQ-1:0] mask);
    for (int i = 1; i <= NREQ; i++) begin
      int j;
      j = (model_last + i) % NREQ;
      if (mask[j]) return j;
    end
    return -1;
  endfunction

  // Array model: reset by mm_nreset, answers lat cycles after start (0 = never).
  always @(posedge clock) begin
    mm_ready <= 1'b0;
    if (!mm_nreset) begin
      arr_cnt <= 0;
      mm_c    <= '0;
    end else if (mm_valid) begin
      if (arr_lat == 1) begin
        mm_ready <= 1'b1;
        mm_c     <= mat_mul(mm_a, mm_b);
        arr_cnt  <= 0;
      end else begin
        arr_cnt <= (arr_lat == 0) ? 0 : arr_lat - 1;
      end
    end else if (arr_cnt > 0) begin
      arr_cnt <= arr_cnt - 1;
      if (arr_cnt == 1) begin
        mm_ready <= 1'b1;
        mm_c     <= mat_mul(mm_a, mm_b);
      end
    end else if (stray_en) begin
      mm_ready <= 1'b1;
      mm_c     <= '1;
    end
  end

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One full job: grant, exact CLEAR/START timing, operand hold, latency, stall, handshake.
  task automatic run_job(input logic [NREQ-1:0] mask, input int lat, input int hold,
                         input int exp_id, input logic exp_err, input res_t exp_c);
    mat_t ea, eb;
    int   seen_k, exp_k, w;
    ea      = req_a[exp_id];
    eb      = req_b[exp_id];
    arr_lat = lat;
    exp_k   = (lat == 0) ? 3 + TIMEOUT_CYC : 3 + lat;
    req_valid = mask;
    rsp_ready = 1'b0;
    #1;
    w = 0;
    while (req_ready == '0 && w < 8) begin
      @(negedge clock); #1; w++;
    end
    check("grant", req_ready, NREQ'(1) << exp_id);
    model_last = exp_id;
    seen_k = 0;
    for (int k = 1; k <= 60 && seen_k == 0; k++) begin
      @(negedge clock);
      check("no_grant_busy", req_ready, '0);
      check("mm_nreset_seq", mm_nreset, (k != 1));
      check("mm_valid_seq", mm_valid, (k == 2));
      check("mm_a_hold", mm_a, ea);
      check("mm_b_hold", mm_b, eb);
      if (rsp_valid) begin
        seen_k = k;
        check("latency", k, exp_k);
        rsp_ready = (hold == 0);
      end else begin
        req_valid = NREQ'($urandom);
        req_a     = {rand_mat(), rand_mat()};
        req_b     = {rand_mat(), rand_mat()};
        rsp_ready = 1'($urandom);
      end
    end
    if (seen_k == 0) check("rsp_valid_wait", rsp_valid, 1'b1);
    check("rsp_id", rsp_id, exp_id);
    check("rsp_c", rsp_c, exp_c);
    check("rsp_err", rsp_err, exp_err);
    stray_en = 1'b1;
    for (int h = 1; h <= hold; h++) begin
      @(negedge clock);
      check("stall_valid", rsp_valid, 1'b1);
      check("stall_c", rsp_c, exp_c);
      check("stall_id", rsp_id, exp_id);
      check("stall_no_grant", req_ready, '0);
      req_valid = NREQ'($urandom);
      if (h == hold) rsp_ready = 1'b1;
    end
    @(negedge clock);
    check("rsp_drop", rsp_valid, 1'b0);
    stray_en  = 1'b0;
    rsp_ready = 1'b0;
    req_valid = '0;
  endtask

  task automatic load_ops(input int kind, input int id, output res_t exp_c);
    req_a = {rand_mat(), rand_mat()};
    req_b = {rand_mat(), rand_mat()};
    if (kind == 1) begin
      for (int r = 0; r < SIZE; r++)
        for (int col = 0; col < SIZE; col++) begin
          req_a[id][r][col] = WIDTHX'(r == col);
          req_b[id][r][col] = WIDTHX'(r * SIZE + col + 1);
          exp_c[r][col]     = WIDTH'(r * SIZE + col + 1);
        end
    end else if (kind == 2) begin
      for (int r = 0; r < SIZE; r++)
        for (int col = 0; col < SIZE; col++) begin
          req_a[id][r][col] = (r == col) ? WIDTHX'(2) : WIDTHX'(0);
          req_b[id][r][col] = WIDTHX'(3);
          exp_c[r][col]     = WIDTH'(6);
        end
    end else begin
      exp_c = mat_mul(req_a[id], req_b[id]);
    end
  endtask

  vec_t tbl[8];
  res_t ec;

  initial begin
    tbl[0] = '{mask: 2'b11, lat: 2, hold: 0, kind: 0, exp_id: 0};
    tbl[1] = '{mask: 2'b11, lat: 1, hold: 5, kind: 0, exp_id: 1};
    tbl[2] = '{mask: 2'b11, lat: 3, hold: 0, kind: 0, exp_id: 0};
    tbl[3] = '{mask: 2'b01, lat: 1, hold: 2, kind: 1, exp_id: 0};
    tbl[4] = '{mask: 2'b10, lat: 4, hold: 0, kind: 0, exp_id: 1};
    tbl[5] = '{mask: 2'b10, lat: 2, hold: 1, kind: 0, exp_id: 1};
    tbl[6] = '{mask: 2'b11, lat: 1, hold: 0, kind: 0, exp_id: 0};
    tbl[7] = '{mask: 2'b11, lat: 1, hold: 0, kind: 2, exp_id: 1};

    nreset    = 1'b0;
    req_valid = 2'b11;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_req_ready", req_ready, '0);
    check("rst_mm_nreset", mm_nreset, 1'b0);
    check("rst_mm_valid", mm_valid, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_rsp_id", rsp_id, '0);
    check("rst_rsp_c", rsp_c, '0);
    check("rst_mm_a", mm_a, '0);
    check("rst_mm_b", mm_b, '0);
    req_valid = '0;
    nreset    = 1'b1;
    #1;
    check("rel_mm_nreset", mm_nreset, 1'b1);
    @(negedge clock);

    foreach (tbl[i]) begin
      load_ops(tbl[i].kind, tbl[i].exp_id, ec);
      run_job(tbl[i].mask, tbl[i].lat, tbl[i].hold, tbl[i].exp_id, 1'b0, ec);
    end

    // Abort a job mid-RUN; without the reset the next contested grant would go to 1.
    load_ops(0, 0, ec);
    arr_lat   = 5;
    req_valid = 2'b01;
    #1;
    check("abort_grant", req_ready, 2'b01);
    repeat (3) @(negedge clock);
    req_valid = '0;
    nreset    = 1'b0;
    #1;
    check("abort_mm_nreset_low", mm_nreset, 1'b0);
    @(negedge clock);
    check("abort_rsp_valid", rsp_valid, 1'b0);
    check("abort_mm_valid", mm_valid, 1'b0);
    check("abort_mm_a", mm_a, '0);
    check("abort_rsp_c", rsp_c, '0);
    check("abort_mm_nreset_hold", mm_nreset, 1'b0);
    nreset = 1'b1;
    #1;
    check("abort_mm_nreset_rel", mm_nreset, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("abort_no_rsp", rsp_valid, 1'b0);
    end
    model_last = NREQ - 1;
    load_ops(0, 0, ec);
    run_job(2'b11, 2, 0, rr_pick(2'b11), 1'b0, ec);

`ifdef SYSTOLIC_SCHED_TIMEOUT_EN
    load_ops(0, rr_pick(2'b11), ec);
    run_job(2'b11, 0, 1, rr_pick(2'b11), 1'b1, '0);
    load_ops(0, rr_pick(2'b11), ec);
    run_job(2'b11, 3, 0, rr_pick(2'b11), 1'b0, ec);
`endif

    for (int n = 0; n < 16; n++) begin
      logic [NREQ-1:0] m;
      int              id;
      m  = NREQ'($urandom_range(1, 3));
      id = rr_pick(m);
      load_ops(0, id, ec);
      run_job(m, $urandom_range(1, 6), $urandom_range(0, 3), id, 1'b0, ec);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_job_scheduler.md
SYSTOLIC_JOB_SCHEDULER -- requirements
Module: systolic_job_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 16, result element width.
REQ-002 SHALL have parameter WIDTHx, default 4, operand element width.
REQ-003 SHALL have parameter SIZE, default 3, matrix order.
REQ-004 SHALL have parameter NREQ, default 2, number of requesters; legal range 2..8.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 4*SIZE+4, maximum RUN cycles.
REQ-006 SHALL have ports:
- clock  in  1  single clock
- nreset  in  1  synchronous active-low reset
- req_valid  in  NREQ  job request per requester
- req_ready  out  NREQ  one-hot accept pulse
- req_a  in  [NREQ][SIZE][SIZE] x WIDTHx  operand A per requester
- req_b  in  [NREQ][SIZE][SIZE] x WIDTHx  operand B per requester
- mm_nreset  out  1  array reset, active-low
- mm_valid  out  1  array start
- mm_a, mm_b  out  [SIZE][SIZE] x WIDTHx  held operands
- mm_ready  in  1  array completion pulse
- mm_c  in  [SIZE][SIZE] x WIDTH  array product
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accept
- rsp_id  out  $clog2(NREQ)  granted requester index
- rsp_c  out  [SIZE][SIZE] x WIDTH  captured product
- rsp_err  out  1  job timed out

Function
REQ-007 SHALL implement FSM IDLE -> CLEAR -> START -> RUN -> DONE -> IDLE.
REQ-008 IDLE: any req_valid set -> round-robin grant, req_ready[g]=1 for that cycle only, latch req_a[g]/req_b[g] into mm_a/mm_b, latch g into rsp_id, go CLEAR.
REQ-009 Round-robin: search starts at requester after last grant; after reset requester 0 has highest priority.
REQ-010 CLEAR: mm_nreset=0 for exactly 1 cycle; this clears the array's sticky start latch and counter; go START.
REQ-011 START: mm_valid=1 for exactly 1 cycle; go RUN.
REQ-012 RUN: on mm_ready=1, capture mm_c into rsp_c in that cycle, rsp_err=0, go DONE; mm_ready is a 1-cycle pulse and is never missed.
REQ-013 mm_ready outside RUN SHALL be ignored.
REQ-014 DONE: rsp_valid=1, rsp_c/rsp_id/rsp_err stable until rsp_ready=1; on the handshake cycle go IDLE.
REQ-015 rsp_ready=1 with rsp_valid=0 SHALL have no effect.
REQ-016 mm_a/mm_b SHALL stay constant from CLEAR through DONE.
REQ-017 req_valid changes outside IDLE SHALL be ignored; no requests are queued internally.
REQ-018 Minimum job latency: accept cycle to rsp_valid = 3 cycles plus array compute time.

Reset
REQ-019 nreset=0 at a clock edge SHALL force IDLE, req_ready=0, mm_valid=0, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_c=0, mm_a=0, mm_b=0, arbiter pointer to requester NREQ-1.
REQ-020 mm_nreset SHALL be 0 whenever nreset=0 or state is CLEAR, else 1.
REQ-021 Reset in any state, including mid-RUN, SHALL abandon the job with no response issued.

Configuration
REQ-022 Macro SYSTOLIC_SCHED_TIMEOUT_EN defined: RUN-cycle counter; reaching TIMEOUT_CYC without mm_ready -> rsp_c=0, rsp_err=1, go DONE.
REQ-023 Macro undefined: no counter; RUN waits indefinitely; rsp_err tied 0.

Structure
REQ-024 Package systolic_sched_pkg SHALL hold the FSM state enum and the requester-index width function.
REQ-025 Arbitration SHALL be a sub-module rr_arbiter (NREQ request, one-hot grant, pointer update on advance).

Verification (SIZE=3, NREQ=2)
REQ-026 Requester 0: A=identity, B=[1..9] row-major -> rsp_c=[1..9], rsp_id=0, rsp_err=0.
REQ-027 Both req_valid held for 3 jobs -> grants 0,1,0; req_ready is one-hot and 1 cycle wide.
REQ-028 rsp_ready low 5 cycles in DONE -> rsp_valid, rsp_c, rsp_id stable; no new req_ready until handshake.
REQ-029 nreset low 1 cycle mid-RUN -> IDLE next cycle, rsp_valid=0, mm_nreset=0 during reset, next job starts cleanly with 0 priority.
REQ-030 SYSTOLIC_SCHED_TIMEOUT_EN, mm_ready forced 0 -> DONE after TIMEOUT_CYC=16 RUN cycles, rsp_err=1, rsp_c=0.
REQ-031 Back-to-back jobs -> exactly one mm_nreset low cycle then one mm_valid cycle per job; second result correct (A=2I, B=all 3 -> rsp_c all 6).
